// File: rtl/triangle_fifo_reader.sv
// Triangle FIFO reader: pops triangles, drops degenerate ones, presents the rest with a clamped bounding box.
// Latency: fifo_r in cycle N -> tri_valid in cycle N+3 for a non-degenerate triangle.
// Backpressure: holds tri_out/bbox/tri_valid until tri_ready; no FIFO read while holding.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   draw_start          level request to draw a frame; draw_done reports the FIFO drained
//   fifo_empty, fifo_r  FIFO status / read strobe; fifo_dout is valid the cycle after fifo_r
//   tri_valid/ready     handshake to the rasterizer for tri_out and bbox_*
//   tri_count/drop_count per-frame dispatched / dropped triangle counters (saturating)
module triangle_fifo_reader (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   draw_start,
    input  logic                   fifo_empty,
    output logic                   fifo_r,
    input  logic [2:0][1:0][9:0]   fifo_dout,
    output logic                   tri_valid,
    input  logic                   tri_ready,
    output logic [2:0][1:0][9:0]   tri_out,
    output logic [9:0]             bbox_xmin,
    output logic [9:0]             bbox_xmax,
    output logic [9:0]             bbox_ymin,
    output logic [9:0]             bbox_ymax,
    output logic                   draw_done,
    output logic [15:0]            tri_count,
    output logic [15:0]            drop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LATCH,
        S_EVAL,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [9:0] X_LIMIT = 10'd639;
    localparam logic [9:0] Y_LIMIT = 10'd479;

    state_t               state_q;
    logic [2:0][1:0][9:0] tri_q;
    logic [9:0]           bbox_xmin_q, bbox_xmax_q, bbox_ymin_q, bbox_ymax_q;
    logic                 tri_valid_q;
    logic                 draw_done_q;
    logic [15:0]          tri_count_q, drop_count_q;

    logic signed [10:0]   dx1, dy1, dx2, dy2;
    logic signed [22:0]   area2_d;
    logic [9:0]           bbox_xmin_d, bbox_xmax_d, bbox_ymin_d, bbox_ymax_d;

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Twice the signed triangle area from the latched vertexes; zero means degenerate.
    // Deltas are 11-bit signed, so each product fits in 22 bits and the difference in 23.
    always_comb begin
        dx1     = $signed({1'b0, tri_q[1][0]}) - $signed({1'b0, tri_q[0][0]});
        dy1     = $signed({1'b0, tri_q[1][1]}) - $signed({1'b0, tri_q[0][1]});
        dx2     = $signed({1'b0, tri_q[2][0]}) - $signed({1'b0, tri_q[0][0]});
        dy2     = $signed({1'b0, tri_q[2][1]}) - $signed({1'b0, tri_q[0][1]});
        area2_d = (23'(dx1) * 23'(dy2)) - (23'(dx2) * 23'(dy1));
    end

    always_comb begin
        bbox_xmin_d = clamp(min3(tri_q[0][0], tri_q[1][0], tri_q[2][0]), X_LIMIT);
        bbox_xmax_d = clamp(max3(tri_q[0][0], tri_q[1][0], tri_q[2][0]), X_LIMIT);
        bbox_ymin_d = clamp(min3(tri_q[0][1], tri_q[1][1], tri_q[2][1]), Y_LIMIT);
        bbox_ymax_d = clamp(max3(tri_q[0][1], tri_q[1][1], tri_q[2][1]), Y_LIMIT);
    end

    // The read strobe must follow fifo_empty within the Check cycle itself, so it is
    // decoded from the state rather than registered.
    assign fifo_r = (state_q == S_CHECK) && !fifo_empty;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            tri_q        <= '0;
            bbox_xmin_q  <= '0;
            bbox_xmax_q  <= '0;
            bbox_ymin_q  <= '0;
            bbox_ymax_q  <= '0;
            tri_valid_q  <= 1'b0;
            draw_done_q  <= 1'b0;
            tri_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (draw_start) begin
                        tri_count_q  <= '0;
                        drop_count_q <= '0;
                        state_q      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (fifo_empty) begin
                        draw_done_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        state_q     <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    tri_q   <= fifo_dout;
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    bbox_xmin_q <= bbox_xmin_d;
                    bbox_xmax_q <= bbox_xmax_d;
                    bbox_ymin_q <= bbox_ymin_d;
                    bbox_ymax_q <= bbox_ymax_d;
                    if (area2_d == '0) begin
                        if (drop_count_q != 16'hFFFF) begin
                            drop_count_q <= drop_count_q + 16'd1;
                        end
                        state_q <= S_CHECK;
                    end else begin
                        tri_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (tri_ready) begin
                        tri_valid_q <= 1'b0;
                        if (tri_count_q != 16'hFFFF) begin
                            tri_count_q <= tri_count_q + 16'd1;
                        end
                        state_q <= S_CHECK;
                    end
                end
                S_DONE: begin
                    if (!draw_start) begin
                        draw_done_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tri_out    = tri_q;
    assign bbox_xmin  = bbox_xmin_q;
    assign bbox_xmax  = bbox_xmax_q;
    assign bbox_ymin  = bbox_ymin_q;
    assign bbox_ymax  = bbox_ymax_q;
    assign tri_valid  = tri_valid_q;
    assign draw_done  = draw_done_q;
    assign tri_count  = tri_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: doc/triangle_fifo_reader.md
TRIANGLE_FIFO_READER -- requirements
Module: triangle_fifo_reader

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003 draw_start  input  1  level; high = frame draw requested (screen clear complete).
REQ-004 fifo_empty  input  1  triangle FIFO has no entries.
REQ-005 fifo_r  output  1  FIFO read enable; one entry popped per high cycle.
REQ-006 fifo_dout  input  [2:0][1:0][9:0]  FIFO read data, valid the cycle after fifo_r; [v][0]=x, [v][1]=y.
REQ-007 tri_valid  output  1  triangle and bounding box on outputs are valid.
REQ-008 tri_ready  input  1  rasterizer accepts the triangle when high with tri_valid.
REQ-009 tri_out  output  [2:0][1:0][9:0]  registered triangle vertexes.
REQ-010 bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax  output  10 each  clamped bounding box.
REQ-011 draw_done  output  1  FIFO drained for this frame.
REQ-012 tri_count, drop_count  output  16 each  triangles dispatched / degenerate triangles dropped this frame.

Function
REQ-013 States: Idle, Check, Latch, Eval, Hold, Done; one state per cycle except Hold and Done.
REQ-014 Idle: when draw_start=1, clear tri_count and drop_count and go to Check; otherwise stay.
REQ-015 Check: if fifo_empty=1, go to Done with fifo_r=0; else assert fifo_r for exactly this cycle and go to Latch.
REQ-016 Latch: register fifo_dout into tri_out; go to Eval; fifo_r=0.
REQ-017 Eval: compute area2 = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0) as signed 23-bit from tri_out; register bounding box; if area2=0 increment drop_count and go to Check, else go to Hold.
REQ-018 Bounding box: min/max of the three x and three y values; bbox_xmax clamped to 639, bbox_ymax to 479; bbox_xmin/ymin clamped to same limits.
REQ-019 Hold: tri_valid=1; tri_out and bbox stable; on tri_ready=1 increment tri_count and go to Check; else stay.
REQ-020 Latency: fifo_r high in cycle N -> tri_valid first high in cycle N+3 for a non-degenerate triangle.
REQ-021 Done: draw_done=1; when draw_start=0 go to Idle; stay otherwise.
REQ-022 draw_start deasserted mid-frame does not abort; the FIFO is drained to empty before Done.
REQ-023 fifo_r never asserted while fifo_empty=1, nor outside Check.
REQ-024 Counters saturate at 16'hFFFF; counters hold their values in Done and Idle until the next frame start.
REQ-025 tri_valid never deasserted in Hold before handshake completes.

Reset
REQ-026 Reset=1: state Idle; fifo_r, tri_valid, draw_done=0; tri_out, bbox, tri_count, drop_count=0; applies from any state, including mid-Hold.
REQ-027 A FIFO entry popped before a mid-operation reset is discarded, not replayed.

Verification
REQ-028 FIFO holds (100,140),(140,120),(120,160); draw_start=1, tri_ready=1 -> tri_valid at N+3, bbox x 100..140, y 120..160, tri_count=1, then draw_done.
REQ-029 Entry (10,10),(20,20),(30,30) followed by a valid triangle -> first dropped (drop_count=1, no tri_valid), second dispatched (tri_count=1).
REQ-030 Vertex (700,500),(20,30),(60,10) -> bbox_xmax=639, bbox_ymax=479, xmin=20, ymin=10.
REQ-031 tri_ready held 0 for 5 cycles in Hold -> tri_valid and tri_out stable 5 cycles, no fifo_r; accept on cycle 6.
REQ-032 fifo_empty=1 at draw_start -> Idle, Check, Done: draw_done high 2 cycles after start, fifo_r never high; draw_start=0 -> Idle.
REQ-033 Reset asserted during Hold -> next cycle all outputs 0, state Idle; restart drains remaining entries normally.
